dram_timing_counter_bank: RTL and testbench

- Bank of NUM_CH independent, parametrised-width DRAM timing counters for one rank or bank group.
- Each channel enforces one timing constraint, such as tRCD, tRP, tWR, tRFC or tREFI.
- New versus the single counter:
  - per-channel one-shot or periodic mode;
  - max-merge on re-setup, so overlapping constraints never shorten a pending wait;
  - level ready output in addition to the expiry pulse;
  - global flush.
- Sits between the rank FSM and the command scheduler. The scheduler gates commands on ready; the FSM reacts to time_up.

---
 rtl/dram_timing_pkg.sv | 22 ++
 rtl/dram_timing_counter_ch.sv | 98 +++++++++
 rtl/dram_timing_counter_bank.sv | 44 ++++
 tb/tb_dram_timing_counter_bank.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_timing_pkg.sv
// Shared types and helpers for the DRAM timing counter bank.
// The optional DTC_BUSY_CYCLES_EN macro is consumed by the channel and bank files.
package dram_timing_pkg;

  typedef enum logic {
    DTC_ONESHOT  = 1'b0,
    DTC_PERIODIC = 1'b1
  } dtc_mode_e;

  localparam int DTC_BUSY_W = 16;

  // Widest counter the max helper supports; callers zero-extend and truncate.
  localparam int DTC_MAX_W = 32;

  function automatic logic [DTC_MAX_W-1:0] dtc_max(
    input logic [DTC_MAX_W-1:0] a,
    input logic [DTC_MAX_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dram_timing_counter_ch.sv
// One DRAM timing channel: down-counter with max-merge re-setup, one-shot or
// periodic reload, registered expiry pulse and (with DTC_BUSY_CYCLES_EN) a busy counter.
module dram_timing_counter_ch
  import dram_timing_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             setup_i,
  input  logic [CNT_W-1:0] load_i,
  input  logic             periodic_i,
  input  logic             stop_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             time_up_o
`ifdef DTC_BUSY_CYCLES_EN
  ,
  output logic [DTC_BUSY_W-1:0] busy_cycles_o
`endif
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic [CNT_W-1:0] dec;
  dtc_mode_e        mode_q, mode_d;
  logic             time_up_q, time_up_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    count_d   = count_q;
    reload_d  = reload_q;
    mode_d    = mode_q;
    time_up_d = 1'b0;
    dec       = (count_q != '0) ? (count_q - ONE) : '0;

    if (flush_i || stop_i) begin
      count_d = '0;
      mode_d  = DTC_ONESHOT;
    end else if (setup_i) begin
      // Merge with the pending wait so a shorter constraint never cuts it short.
      count_d   = CNT_W'(dtc_max(DTC_MAX_W'(dec), DTC_MAX_W'(load_i)));
      reload_d  = load_i;
      mode_d    = periodic_i ? DTC_PERIODIC : DTC_ONESHOT;
      time_up_d = (count_q == ONE) && (load_i == '0);
    end else if (count_q > ONE) begin
      count_d = dec;
    end else if (count_q == ONE) begin
      count_d   = (mode_q == DTC_PERIODIC && reload_q != '0) ? reload_q : '0;
      time_up_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      reload_q  <= '0;
      mode_q    <= DTC_ONESHOT;
      time_up_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      reload_q  <= reload_d;
      mode_q    <= mode_d;
      time_up_q <= time_up_d;
    end
  end

  assign ready_o   = (count_q == '0);
  assign time_up_o = time_up_q;

`ifdef DTC_BUSY_CYCLES_EN
  logic [DTC_BUSY_W-1:0] busy_q, busy_d;

  // Saturating occupancy counter; stop leaves it alone, flush clears it.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else if (count_q != '0 && busy_q != '1) begin
      busy_d = busy_q + DTC_BUSY_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_cycles_o = busy_q;
`endif

endmodule

// File: rtl/dram_timing_counter_bank.sv
// Bank of NUM_CH independent DRAM timing counters with a global flush.
// Define DTC_BUSY_CYCLES_EN to add the per-channel busy_cycles output.
module dram_timing_counter_bank
  import dram_timing_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       setup,
  input  logic [NUM_CH*CNT_W-1:0] load,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH-1:0]       stop,
  input  logic                    flush,
  output logic [NUM_CH-1:0]       ready,
  output logic [NUM_CH-1:0]       time_up
`ifdef DTC_BUSY_CYCLES_EN
  ,
  output logic [NUM_CH*DTC_BUSY_W-1:0] busy_cycles
`endif
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    dram_timing_counter_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .setup_i      (setup[i]),
      .load_i       (load[i*CNT_W +: CNT_W]),
      .periodic_i   (periodic[i]),
      .stop_i       (stop[i]),
      .flush_i      (flush),
      .ready_o      (ready[i]),
      .time_up_o    (time_up[i])
`ifdef DTC_BUSY_CYCLES_EN
      ,
      .busy_cycles_o(busy_cycles[i*DTC_BUSY_W +: DTC_BUSY_W])
`endif
    );
  end

endmodule

// File: tb/tb_dram_timing_counter_bank.sv
// Self-checking bench for dram_timing_counter_bank: directed scenarios plus random
// traffic against a deadline-based reference model.
module tb_dram_timing_counter_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int BUSY_W = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       setup;
  logic [NUM_CH*CNT_W-1:0] load;
  logic [NUM_CH-1:0]       periodic;
  logic [NUM_CH-1:0]       stop;
  logic                    flush;
  logic [NUM_CH-1:0]       ready;
  logic [NUM_CH-1:0]       time_up;
`ifdef DTC_BUSY_CYCLES_EN
  logic [NUM_CH*BUSY_W-1:0] busy_cycles;
`endif

  dram_timing_counter_bank #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .setup      (setup),
    .load       (load),
    .periodic   (periodic),
    .stop       (stop),
    .flush      (flush),
    .ready      (ready),
    .time_up    (time_up)
`ifdef DTC_BUSY_CYCLES_EN
    ,
    .busy_cycles(busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a channel is a deadline (edge index at which it reaches zero), not a count.
  longint t = 0;
  bit     m_active[NUM_CH];
  longint m_exp[NUM_CH];
  int     m_reload[NUM_CH];
  bit     m_per[NUM_CH];
  bit     m_pulse[NUM_CH];
  int     m_busy[NUM_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_active[i] = 1'b0;
      m_exp[i]    = 0;
      m_reload[i] = 0;
      m_per[i]    = 1'b0;
      m_pulse[i]  = 1'b0;
      m_busy[i]   = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < NUM_CH; i++) begin
      int     ld;
      bit     was_active;
      longint ne;
      ld         = int'(load[i*CNT_W +: CNT_W]);
      was_active = m_active[i];
      m_pulse[i] = 1'b0;
      if (flush || stop[i]) begin
        m_active[i] = 1'b0;
        m_per[i]    = 1'b0;
      end else if (setup[i]) begin
        ne = t + ld;
        if (m_active[i] && m_exp[i] > ne) ne = m_exp[i];
        m_pulse[i]  = m_active[i] && (m_exp[i] == t) && (ne == t);
        m_active[i] = (ne > t);
        m_exp[i]    = ne;
        m_reload[i] = ld;
        m_per[i]    = periodic[i];
      end else if (m_active[i] && m_exp[i] == t) begin
        m_pulse[i] = 1'b1;
        if (m_per[i] && m_reload[i] != 0) m_exp[i] = t + m_reload[i];
        else m_active[i] = 1'b0;
      end
      if (flush) m_busy[i] = 0;
      else if (was_active && m_busy[i] < 65535) m_busy[i]++;
    end
    t++;
  endtask

  task automatic check_all();
    for (int i = 0; i < NUM_CH; i++) begin
      check($sformatf("ready[%0d]@%0d", i, t), 32'(ready[i]), 32'(!m_active[i]));
      check($sformatf("time_up[%0d]@%0d", i, t), 32'(time_up[i]), 32'(m_pulse[i]));
`ifdef DTC_BUSY_CYCLES_EN
      check($sformatf("busy[%0d]@%0d", i, t), 32'(busy_cycles[i*BUSY_W +: BUSY_W]), 32'(m_busy[i]));
`endif
    end
  endtask

  // One clock: DUT and model see the same inputs, outputs compared at the falling edge,
  // then single-cycle strobes are dropped.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    setup = '0;
    stop  = '0;
    flush = 1'b0;
  endtask

  task automatic arm(input int ch, input int ld, input bit per);
    setup[ch]              = 1'b1;
    load[ch*CNT_W +: CNT_W] = CNT_W'(ld);
    periodic[ch]           = per;
  endtask

  int first_pulse;
  int n_pulse;
  int pulse_at[$];

  initial begin
    rst      = 1'b0;
    setup    = '0;
    load     = '0;
    periodic = '0;
    stop     = '0;
    flush    = 1'b0;
    model_reset();

    #12;
    check("reset_ready", 32'(ready), 32'({NUM_CH{1'b1}}));
    check("reset_time_up", 32'(time_up), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    step();

    // Ch0 one-shot load 5: pulse in cycle 6 only.
    arm(0, 5, 1'b0);
    first_pulse = 0;
    n_pulse     = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (time_up[0]) begin
        if (n_pulse == 0) first_pulse = c;
        n_pulse++;
      end
    end
    check("ch0_pulse_cycle", 32'(first_pulse), 32'(6));
    check("ch0_pulse_count", 32'(n_pulse), 32'(1));

    // Ch1 load 10, re-setup with 4 during cycle 3: merged wait still ends in cycle 11.
    arm(1, 10, 1'b0);
    first_pulse = 0;
    n_pulse     = 0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 4) arm(1, 4, 1'b0);
      step();
      if (time_up[1]) begin
        if (n_pulse == 0) first_pulse = c;
        n_pulse++;
      end
    end
    check("ch1_merge_pulse_cycle", 32'(first_pulse), 32'(11));
    check("ch1_merge_pulse_count", 32'(n_pulse), 32'(1));

    // Ch2 periodic load 3: pulses in cycles 4 and 7, stop during cycle 8 ends them.
    arm(2, 3, 1'b1);
    pulse_at.delete();
    for (int c = 1; c <= 16; c++) begin
      if (c == 9) stop[2] = 1'b1;
      step();
      if (time_up[2]) pulse_at.push_back(c);
      if (c == 9) check("ch2_ready_after_stop", 32'(ready[2]), 32'(1));
    end
    check("ch2_pulse_total", 32'(pulse_at.size()), 32'(2));
    if (pulse_at.size() == 2) begin
      check("ch2_pulse_a", 32'(pulse_at[0]), 32'(4));
      check("ch2_pulse_b", 32'(pulse_at[1]), 32'(7));
    end

    // Ch3 load 2, flush while count==1: pulse suppressed, all channels idle.
    arm(3, 2, 1'b0);
    n_pulse = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 3) flush = 1'b1;
      step();
      if (time_up[3]) n_pulse++;
    end
    check("ch3_flush_no_pulse", 32'(n_pulse), 32'(0));
    check("ch3_flush_all_ready", 32'(ready), 32'({NUM_CH{1'b1}}));
`ifdef DTC_BUSY_CYCLES_EN
    check("ch3_flush_busy", 32'(busy_cycles[3*BUSY_W +: BUSY_W]), 32'(0));
`endif

    // Asynchronous reset in the middle of a long count.
    arm(0, 200, 1'b0);
    for (int c = 1; c <= 49; c++) step();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("midreset_ready", 32'(ready), 32'({NUM_CH{1'b1}}));
    check("midreset_time_up", 32'(time_up), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    n_pulse = 0;
    for (int c = 1; c <= 250; c++) begin
      step();
      if (time_up != '0) n_pulse++;
    end
    check("postreset_no_pulse", 32'(n_pulse), 32'(0));

    // Random traffic against the model, including load 0, re-setup at expiry, stop and flush.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 5) == 0) begin
          arm(i, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 8)),
              1'($urandom_range(0, 1)));
        end
        if ($urandom_range(0, 39) == 0) stop[i] = 1'b1;
      end
      if ($urandom_range(0, 199) == 0) flush = 1'b1;
      step();
    end

`ifdef DTC_BUSY_CYCLES_EN
    // Long periodic run drives the busy counter into saturation.
    flush = 1'b1;
    step();
    arm(0, 255, 1'b1);
    for (int c = 0; c < 70000; c++) step();
    check("busy0_saturated", 32'(busy_cycles[0 +: BUSY_W]), 32'(65535));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
